player_motion_ctrl: RTL

Sequencing controller for the player character in the VGA game. It turns the debounced up/left/right buttons into a registered character position (`char_x`, `char_y`) and a landing score, stepping the motion once per game tick. A two-state jump/gravity machine drives the vertical position. The rasteriser (`vga_bitchange`-style painter) consumes the position combinationally against `hCount`/`vCount`.

---
 rtl/game_pkg.sv | 34 +++
 rtl/tick_gen.sv | 26 ++
 rtl/player_motion_ctrl.sv | 121 ++++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// Shared constants and types for the VGA game: play-field geometry, motion
// defaults, colours and the player motion state encoding.
package game_pkg;

    localparam int FIELD_X_MIN = 250;
    localparam int FIELD_X_MAX = 700;
    localparam int FIELD_Y_MIN = 200;
    localparam int FIELD_Y_MAX = 350;
    localparam int CHAR_W      = 40;
    localparam int CHAR_H      = 40;

    localparam int DEF_TICK_DIV = 833334;
    localparam int DEF_X_MIN    = FIELD_X_MIN;
    localparam int DEF_X_MAX    = FIELD_X_MAX - CHAR_W;
    localparam int DEF_STEP_X   = 4;
    localparam int DEF_GROUND_Y = 320;
    localparam int DEF_CEIL_Y   = FIELD_Y_MIN;
    localparam int DEF_JUMP_V   = 15;
    localparam int DEF_GRAVITY  = 1;
    localparam int CHAR_X_HOME  = 340;

    // 12-bit RGB (4:4:4) colours used by the painter
    localparam logic [11:0] COLOR_BLACK  = 12'h000;
    localparam logic [11:0] COLOR_WHITE  = 12'hFFF;
    localparam logic [11:0] COLOR_PLAYER = 12'hF80;
    localparam logic [11:0] COLOR_GROUND = 12'h0A0;
    localparam logic [11:0] COLOR_SKY    = 12'h48F;

    typedef enum logic {
        GROUND = 1'b0,
        AIR    = 1'b1
    } motion_state_t;

endpackage

// File: rtl/tick_gen.sv
// Free-running divider: strobes tick for one cycle every DIV clock cycles.
module tick_gen #(
    parameter int DIV = 2
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);
    localparam int W = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + W'(1);
        end
    end

    assign tick = (count == LAST);

endmodule

// File: rtl/player_motion_ctrl.sv
// Player character motion: horizontal stepping with edge clamps, a GROUND/AIR
// jump-gravity machine for the vertical position, and a saturating landing score.
module player_motion_ctrl
    import game_pkg::*;
#(
    parameter int TICK_DIV = DEF_TICK_DIV,
    parameter int X_MIN    = DEF_X_MIN,
    parameter int X_MAX    = DEF_X_MAX,
    parameter int STEP_X   = DEF_STEP_X,
    parameter int GROUND_Y = DEF_GROUND_Y,
    parameter int CEIL_Y   = DEF_CEIL_Y,
    parameter int JUMP_V   = DEF_JUMP_V,
    parameter int GRAVITY  = DEF_GRAVITY
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        up,
    input  logic        left,
    input  logic        right,
    output logic [9:0]  char_x,
    output logic [9:0]  char_y,
    output logic        jumping,
    output logic [15:0] score,
    output logic        tick
);
    localparam logic        [10:0] X_MAX_U  = 11'(X_MAX);
    localparam logic        [10:0] STEP_U   = 11'(STEP_X);
    localparam logic signed [10:0] X_MIN_S  = 11'(X_MIN);
    localparam logic signed [10:0] STEP_S   = 11'(STEP_X);
    localparam logic signed [10:0] GROUND_S = 11'(GROUND_Y);
    localparam logic signed [10:0] CEIL_S   = 11'(CEIL_Y);
    localparam logic signed [6:0]  GRAV_S   = 7'(GRAVITY);
    localparam logic signed [6:0]  VY_FLOOR = -7'(JUMP_V);
    localparam logic        [5:0]  VY_LAUNCH = 6'(JUMP_V - GRAVITY);

    motion_state_t state_reg, state_next;
    logic [9:0]  x_reg, x_next;
    logic [9:0]  y_reg, y_next;
    logic [5:0]  vy_reg, vy_next;
    logic [15:0] score_reg, score_next;

    logic        [10:0] x_inc;
    logic signed [10:0] x_dec;
    logic signed [10:0] y_air;
    logic signed [6:0]  vy_dec;

    tick_gen #(.DIV(TICK_DIV)) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= GROUND;
            x_reg     <= 10'(CHAR_X_HOME);
            y_reg     <= 10'(GROUND_Y);
            vy_reg    <= '0;
            score_reg <= '0;
        end else if (tick) begin
            state_reg <= state_next;
            x_reg     <= x_next;
            y_reg     <= y_next;
            vy_reg    <= vy_next;
            score_reg <= score_next;
        end
    end

    always_comb begin
        x_inc  = {1'b0, x_reg} + STEP_U;
        x_dec  = $signed({1'b0, x_reg}) - STEP_S;
        x_next = x_reg;
        if (right) begin
            x_next = (x_inc > X_MAX_U) ? X_MAX_U[9:0] : x_inc[9:0];
        end else if (left) begin
            x_next = (x_dec < X_MIN_S) ? X_MIN_S[9:0] : x_dec[9:0];
        end
    end

    // vy is positive upward while screen y grows downward, hence y - vy
    always_comb begin
        y_air      = $signed({1'b0, y_reg}) - $signed({{5{vy_reg[5]}}, vy_reg});
        vy_dec     = $signed({vy_reg[5], vy_reg}) - GRAV_S;
        state_next = state_reg;
        y_next     = y_reg;
        vy_next    = vy_reg;
        score_next = score_reg;
        unique case (state_reg)
            GROUND: begin
                if (up) begin
                    state_next = AIR;
                    y_next     = y_reg - 10'(JUMP_V);
                    vy_next    = VY_LAUNCH;
                end
            end
            AIR: begin
                if (y_air >= GROUND_S) begin
                    state_next = GROUND;
                    y_next     = GROUND_S[9:0];
                    vy_next    = '0;
                    if (score_reg != 16'hFFFF) begin
                        score_next = score_reg + 16'd1;
                    end
                end else if (y_air < CEIL_S) begin
                    y_next  = CEIL_S[9:0];
                    vy_next = '0;
                end else begin
                    y_next  = y_air[9:0];
                    vy_next = (vy_dec < VY_FLOOR) ? VY_FLOOR[5:0] : vy_dec[5:0];
                end
            end
            default: state_next = GROUND;
        endcase
    end

    assign char_x  = x_reg;
    assign char_y  = y_reg;
    assign jumping = (state_reg == AIR);
    assign score   = score_reg;

endmodule
